// File: rtl/decoder_proj_pkg.sv
// Shared constants for the seven-segment-to-hex decoder: glyph map, segment bit
// positions and the width of the error counter.
package decoder_proj_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam int ERR_CNT_W  = 8;
    localparam int NUM_GLYPHS = 16;

    // Entry i is the abcdefg pattern that decodes to hex value i.
    localparam logic [6:0] GLYPH_MAP [NUM_GLYPHS] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic logic [4:0] glyphDecode(input logic [6:0] seg);
        logic [4:0] result;
        result = '0;
        for (int i = 0; i < NUM_GLYPHS; i++) begin
            if (seg == GLYPH_MAP[i]) begin
                result = {1'b1, 4'(i)};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/decoder_proj_seg7_lookup.sv
// Combinational exact-match lookup of a raw segment pattern against the glyph map.
module seg7_lookup
    import decoder_proj_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       hit_o,
    output logic [3:0] value_o
);

    logic [6:0] segKey;

    // Gather segments into abcdefg order so the map stays readable if pins move.
    assign segKey = {seg_i[SEG_A], seg_i[SEG_B], seg_i[SEG_C], seg_i[SEG_D],
                     seg_i[SEG_E], seg_i[SEG_F], seg_i[SEG_G]};

    always_comb begin
        hit_o   = 1'b0;
        value_o = 4'd0;
        for (int i = 0; i < NUM_GLYPHS; i++) begin
            if (segKey == GLYPH_MAP[i]) begin
                hit_o   = 1'b1;
                value_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/decoder_proj.sv
// Registers the decoded glyph, flags value changes and counts unrecognised patterns;
// also carries the formal cover/assert harness.
module decoder_proj
    import decoder_proj_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           io_in,
    output logic [3:0]           digit,
    output logic                 valid,
    output logic                 changed,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic       hit;
    logic [3:0] value;

    logic [3:0]           digit_q,   digit_d;
    logic                 valid_q,   valid_d;
    logic                 changed_q, changed_d;
    logic [ERR_CNT_W-1:0] errCnt_q,  errCnt_d;
    logic [3:0]           prev_q,    prev_d;
    logic                 seen_q,    seen_d;

    seg7_lookup uLookup (
        .seg_i   (io_in),
        .hit_o   (hit),
        .value_o (value)
    );

    // Invalid samples leave digit/prev untouched so a gap never fakes a change.
    always_comb begin
        digit_d   = digit_q;
        valid_d   = 1'b0;
        changed_d = 1'b0;
        errCnt_d  = errCnt_q;
        prev_d    = prev_q;
        seen_d    = seen_q;
        if (hit) begin
            digit_d   = value;
            valid_d   = 1'b1;
            changed_d = !seen_q || (value != prev_q);
            prev_d    = value;
            seen_d    = 1'b1;
        end else if (errCnt_q != '1) begin
            errCnt_d = errCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q   <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            errCnt_q  <= '0;
            prev_q    <= '0;
            seen_q    <= 1'b0;
        end else begin
            digit_q   <= digit_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            errCnt_q  <= errCnt_d;
            prev_q    <= prev_d;
            seen_q    <= seen_d;
        end
    end

    assign digit   = digit_q;
    assign valid   = valid_q;
    assign changed = changed_q;
    assign err_cnt = errCnt_q;

`ifdef FORMAL
    logic fPast_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fPast_q <= 1'b0;
        end else begin
            fPast_q <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_GLYPHS; g++) begin : gCover
        cGlyph: cover property (@(posedge clk) disable iff (!rst_n)
            fPast_q && valid && ($past(io_in) == GLYPH_MAP[g]));
    end

    aValidDigit: assert property (@(posedge clk) disable iff (!rst_n)
        (fPast_q && valid) |-> ({1'b1, digit} == glyphDecode($past(io_in))));

    aErrMonotonic: assert property (@(posedge clk) disable iff (!rst_n)
        fPast_q |-> (err_cnt >= $past(err_cnt)));
`endif

endmodule

// File: tb/tb_decoder_proj.sv
// Randomised self-checking bench for decoder_proj against a behavioural reference model.
module tb_decoder_proj;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] io_in;
    logic [3:0] digit;
    logic       valid;
    logic       changed;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_proj dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .io_in   (io_in),
        .digit   (digit),
        .valid   (valid),
        .changed (changed),
        .err_cnt (err_cnt)
    );

    // Hex value i is shown by refGlyph[i] (segments a..g, msb first).
    logic [6:0] refGlyph [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    int mDigit, mValid, mChanged, mErr, mPrev, mSeen;

    function automatic int refValue(input logic [6:0] p);
        int v = -1;
        foreach (refGlyph[i]) if (refGlyph[i] == p) v = i;
        return v;
    endfunction

    function automatic logic [13:0] expVec();
        return {4'(mDigit), 1'(mValid), 1'(mChanged), 8'(mErr)};
    endfunction

    task automatic modelReset();
        mDigit = 0; mValid = 0; mChanged = 0; mErr = 0; mPrev = 0; mSeen = 0;
    endtask

    // Drive one pattern, clock it in, update the model, then settle for sampling.
    task automatic clockIn(input logic [6:0] p);
        int v;
        io_in = p;
        @(posedge clk);
        v = refValue(p);
        if (v >= 0) begin
            mChanged = (mSeen == 0 || v != mPrev) ? 1 : 0;
            mDigit = v; mValid = 1; mPrev = v; mSeen = 1;
        end else begin
            mValid = 0; mChanged = 0;
            mErr = (mErr < 255) ? mErr + 1 : 255;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        io_in = 7'($urandom);
        modelReset();
        #12;
        checks++;
        if ({digit, valid, changed, err_cnt} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h expected %h", {digit, valid, changed, err_cnt}, 14'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first_glyph();
        clockIn(7'b1111001);
        checks++;
        if ({digit, valid, changed, err_cnt} !== {4'd3, 1'b1, 1'b1, 8'd0}) begin
            errors++;
            $display("[TB] FAIL first_glyph: got %h expected %h", {digit, valid, changed, err_cnt}, {4'd3, 1'b1, 1'b1, 8'd0});
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            clockIn(refGlyph[i]);
            checks++;
            if ({digit, valid, changed, err_cnt} !== expVec()) begin
                errors++;
                $display("[TB] FAIL sweep[%0d]: got %h expected %h", i, {digit, valid, changed, err_cnt}, expVec());
            end
        end
    endtask

    task automatic test_invalid_gap();
        logic [6:0] seq [3] = '{7'b1111001, 7'b0000000, 7'b1111001};
        logic [13:0] want [3];
        want[0] = {4'd3, 1'b1, 1'b1, 8'd0};
        want[1] = {4'd3, 1'b0, 1'b0, 8'd1};
        want[2] = {4'd3, 1'b1, 1'b0, 8'd1};
        rst_n = 1'b0;
        modelReset();
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            clockIn(seq[i]);
            checks++;
            if ({digit, valid, changed, err_cnt} !== want[i] || expVec() !== want[i]) begin
                errors++;
                $display("[TB] FAIL invalid_gap[%0d]: got %h expected %h", i, {digit, valid, changed, err_cnt}, want[i]);
            end
        end
    endtask

    task automatic test_repeat();
        clockIn(refGlyph[5]);
        clockIn(refGlyph[5]);
        checks++;
        if ({digit, valid, changed, err_cnt} !== expVec()) begin
            errors++;
            $display("[TB] FAIL repeat_glyph: got %h expected %h", {digit, valid, changed, err_cnt}, expVec());
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            clockIn(7'b0000001);
            checks++;
            if ({digit, valid, changed, err_cnt} !== expVec()) begin
                errors++;
                $display("[TB] FAIL saturate[%0d]: got %h expected %h", i, {digit, valid, changed, err_cnt}, expVec());
            end
        end
        checks++;
        if (err_cnt !== 8'd255 || valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL saturate_final: got err=%0d valid=%b expected err=255 valid=0", err_cnt, valid);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            clockIn(7'b1111111);
            checks++;
            if ({digit, valid, changed, err_cnt} !== expVec()) begin
                errors++;
                $display("[TB] FAIL pre_reset[%0d]: got %h expected %h", i, {digit, valid, changed, err_cnt}, expVec());
            end
        end
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checks++;
        if ({digit, valid, changed, err_cnt} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected %h", {digit, valid, changed, err_cnt}, 14'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clockIn(7'b1111111);
        checks++;
        if ({digit, valid, changed, err_cnt} !== {4'd8, 1'b1, 1'b1, 8'd0}) begin
            errors++;
            $display("[TB] FAIL post_reset: got %h expected %h", {digit, valid, changed, err_cnt}, {4'd8, 1'b1, 1'b1, 8'd0});
        end
    endtask

    task automatic test_exhaustive();
        int hits = 0;
        for (int p = 0; p < 128; p++) begin
            clockIn(7'(p));
            if (valid === 1'b1) hits++;
            checks++;
            if ({digit, valid, changed, err_cnt} !== expVec()) begin
                errors++;
                $display("[TB] FAIL exhaustive[%b]: got %h expected %h", 7'(p), {digit, valid, changed, err_cnt}, expVec());
            end
        end
        checks++;
        if (hits != 16) begin
            errors++;
            $display("[TB] FAIL exhaustive_hits: got %0d expected 16", hits);
        end
    endtask

    task automatic test_random();
        logic [6:0] p;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 2) != 0) p = refGlyph[$urandom_range(0, 15)];
            else p = 7'($urandom);
            clockIn(p);
            checks++;
            if ({digit, valid, changed, err_cnt} !== expVec()) begin
                errors++;
                $display("[TB] FAIL random[%0d] in=%b: got %h expected %h", i, p, {digit, valid, changed, err_cnt}, expVec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_glyph();
        test_sweep();
        test_invalid_gap();
        test_repeat();
        test_saturation();
        test_async_reset();
        test_exhaustive();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_proj.md
# decoder_proj

Seven-segment-to-hex decoder. Takes a raw 7-bit segment pattern on `io_in`, recognises the 16 canonical hex glyphs, and presents the decoded nibble with a valid flag one clock later. It also keeps a saturating count of unrecognised patterns and pulses when the decoded value changes. It sits behind a segment-capture front end and is the top level for the formal cover and assert harness.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `io_in`  in  7  segment pattern, bit6..bit0 = a,b,c,d,e,f,g; 1 = segment lit.
- `digit`  out  4  decoded hex value, registered.
- `valid`  out  1  registered; 1 when the last sampled `io_in` was a recognised glyph.
- `changed`  out  1  one-cycle pulse when a valid decode differs from the previous valid decode.
- `err_cnt`  out  8  saturating count of cycles that sampled an unrecognised pattern.

## Operation
- Glyph map, as `io_in` → value:
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3
  - 0110011→4, 1011011→5, 1011111→6, 1110000→7
  - 1111111→8, 1111011→9, 1110111→A, 0011111→b
  - 1001110→C, 0111101→d, 1001111→E, 1000111→F
- Every other pattern is invalid. This includes all-zero, 1110011 (9 without tail) and 0011111-like variants not in the list.
- Lookup is purely combinational, exact match only. The map lives in the package as a constant.
- Each cycle, the decode result is registered:
  - Recognised pattern: `valid`=1 and `digit`=value.
  - Unrecognised pattern: `valid`=0, `digit` holds its previous value, and `err_cnt` increments, saturating at 255. It never wraps.
- `changed`=1 in the cycle after a recognised pattern whose value differs from the last recognised value. A previous-value register, plus a seen-first flag, tracks this.
  - The first valid decode after reset asserts `changed`.
  - Invalid cycles between two equal valid values do not assert `changed`.
- Formal harness, inside the block under `ifdef FORMAL`:
  - cover each of the 16 glyphs producing `valid`.
  - assert `valid`→`digit` equals the map of the previous `io_in`.
  - assert `err_cnt` never decreases except through reset.

## Timing
- Latency of exactly 1 clock from an `io_in` sample to `digit`/`valid`/`changed`/`err_cnt`.
- Reset values:
  - `digit`=0, `valid`=0, `changed`=0, `err_cnt`=0.
  - Previous-value register = 0, seen-first flag = 0.
- Asserting `rst_n` mid-stream clears all state immediately, without waiting for a clock edge.
- The first edge after deassertion samples `io_in` normally.
- `io_in` is treated as synchronous to `clk`; no synchroniser inside the block.
- At saturation (`err_cnt`=255), further invalid cycles leave it at 255 and decoding continues normally.

## Structure
- Package `decoder_proj_pkg` holds:
  - the 16-entry glyph constant array,
  - the segment bit-index constants,
  - the `err_cnt` width constant (8).
- One sub-module, `seg7_lookup`: combinational, `io_in` → {hit, value}.
- The top level holds the registers, change detection, error counter and formal properties.

## Test plan
- Reset, then `io_in`=1111001 → after one edge, `digit`=3, `valid`=1, `changed`=1, `err_cnt`=0.
- Sweep all 16 glyphs, one per cycle → `digit` follows 0..F with 1-cycle lag, `valid` is always 1, `changed`=1 every cycle.
- Sequence 1111001, 0000000, 1111001 → `valid` goes 1,0,1; `digit` stays 3 throughout; `changed` pulses only on the first; `err_cnt`=1.
- Hold `io_in`=0000001 for 300 cycles → `err_cnt` reaches and stays at 255, `valid`=0.
- Drive 1111111 for 3 cycles and pull `rst_n` low between edges → all outputs are 0 immediately. After release, the next edge gives `digit`=8, `valid`=1, `changed`=1.
- Exhaustive: all 128 `io_in` values → exactly 16 give `valid`=1, and each matches the map.
